// File: rtl/hs_send_fifo_ctrl.sv
// Source-domain sender for a req/ack CDC handshake: DEPTH-entry word FIFO,
// held-stable data bus, two- or four-phase request, internal b_ack synchroniser.
module hs_send_fifo_ctrl #(
  parameter int WIDTH_D     = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = 0
) (
  input  logic                     aclk,
  input  logic                     arst_n,
  input  logic [WIDTH_D-1:0]       adata,
  input  logic                     asend,
  output logic                     aready,
  input  logic                     b_ack,
  output logic                     a_req,
  output logic [WIDTH_D-1:0]       dout,
  output logic [$clog2(DEPTH):0]   a_level,
  output logic                     a_idle,
  output logic                     a_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_REQ, S_REL} state_t;

  state_t                  r_state, w_state_nxt;
  logic [WIDTH_D-1:0]      r_mem [DEPTH];
  logic [AW-1:0]           r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]           r_level, w_level_nxt;
  logic                    r_aready, r_err;
  logic                    r_req, w_req_nxt;
  logic [WIDTH_D-1:0]      r_dout;
  logic [SYNC_STAGES-1:0]  r_ack_sync;
  logic                    w_ack_s, w_wr, w_pop;

  assign w_wr    = asend & r_aready;
  assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

  // b_ack is asynchronous to aclk; only this chain ever samples it.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) r_ack_sync <= '0;
    else         r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], b_ack};
  end

  // NOTE: the storage array is not reset; validity is tracked by the pointers and level.
  always_ff @(posedge aclk) begin
    if (w_wr) r_mem[r_wr_ptr] <= adata;
  end

  always_comb begin
    w_level_nxt = r_level;
    case ({w_wr, w_pop})
      2'b10:   w_level_nxt = r_level + 1'b1;
      2'b01:   w_level_nxt = r_level - 1'b1;
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_aready <= 1'b1;
      r_err    <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level  <= w_level_nxt;
      r_aready <= (w_level_nxt != FULL_LVL);
      if (asend && !r_aready) r_err <= 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (r_level != '0) w_state_nxt = S_LOAD;
      S_LOAD: w_state_nxt = S_REQ;
      S_REQ: begin
        if (MODE == 0) begin
          if (w_ack_s == r_req) w_state_nxt = S_IDLE;
        end else if (w_ack_s) begin
          w_state_nxt = S_REL;
        end
      end
      S_REL:   if (!w_ack_s) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Two-phase flips a_req per word; four-phase raises it at LOAD and drops it on ack.
  always_comb begin
    w_pop     = 1'b0;
    w_req_nxt = r_req;
    case (r_state)
      S_IDLE:  w_pop = (r_level != '0);
      S_LOAD:  w_req_nxt = (MODE == 0) ? ~r_req : 1'b1;
      S_REQ:   if (MODE != 0 && w_ack_s) w_req_nxt = 1'b0;
      default: w_req_nxt = r_req;
    endcase
  end

  // dout only moves on the IDLE->LOAD edge, so it is stable for the whole transfer.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      r_req  <= 1'b0;
      r_dout <= '0;
    end else begin
      r_req <= w_req_nxt;
      if (w_pop) r_dout <= r_mem[r_rd_ptr];
    end
  end

  assign aready  = r_aready;
  assign a_req   = r_req;
  assign dout    = r_dout;
  assign a_level = r_level;
  assign a_err   = r_err;
  assign a_idle  = (r_state == S_IDLE) && (r_level == '0);

endmodule

// File: tb/tb_hs_send_fifo_ctrl.sv
// Directed bench for hs_send_fifo_ctrl: a two-phase instance (u0) and a
// four-phase instance (u1) share clock and reset; destination acks are scripted.
module tb_hs_send_fifo_ctrl;

  logic aclk   = 1'b0;
  logic arst_n = 1'b1;
  always #5 aclk = ~aclk;

  logic [7:0] adata0 = '0, adata1 = '0;
  logic       asend0 = 1'b0, asend1 = 1'b0;
  logic       b_ack0 = 1'b0, b_ack1 = 1'b0;
  logic       aready0, aready1, a_req0, a_req1, a_idle0, a_idle1, a_err0, a_err1;
  logic [7:0] dout0, dout1;
  logic [2:0] a_level0, a_level1;

  int n_pass  = 0;
  int n_total = 0;

  hs_send_fifo_ctrl #(.WIDTH_D(8), .DEPTH(4), .SYNC_STAGES(2), .MODE(0)) u0 (
    .aclk(aclk), .arst_n(arst_n), .adata(adata0), .asend(asend0), .aready(aready0),
    .b_ack(b_ack0), .a_req(a_req0), .dout(dout0), .a_level(a_level0),
    .a_idle(a_idle0), .a_err(a_err0));

  hs_send_fifo_ctrl #(.WIDTH_D(8), .DEPTH(4), .SYNC_STAGES(2), .MODE(1)) u1 (
    .aclk(aclk), .arst_n(arst_n), .adata(adata1), .asend(asend1), .aready(aready1),
    .b_ack(b_ack1), .a_req(a_req1), .dout(dout1), .a_level(a_level1),
    .a_idle(a_idle1), .a_err(a_err1));

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    asend0 = 1'b0; asend1 = 1'b0; b_ack0 = 1'b0; b_ack1 = 1'b0;
    arst_n = 1'b0;
    repeat (2) @(posedge aclk);
    #1 arst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    asend0 = 1'b1; adata0 = 8'hA5; asend1 = 1'b1; adata1 = 8'h5A;
    arst_n = 1'b0;
    repeat (2) step();
    n_total++; if (dout0 !== 8'h00) $display("FAIL rst_dout got %h want 00", dout0); else n_pass++;
    n_total++; if (a_req0 !== 1'b0) $display("FAIL rst_a_req got %b want 0", a_req0); else n_pass++;
    n_total++; if (aready0 !== 1'b1) $display("FAIL rst_aready got %b want 1", aready0); else n_pass++;
    n_total++; if (a_level0 !== 3'd0) $display("FAIL rst_a_level got %0d want 0", a_level0); else n_pass++;
    n_total++; if (a_idle0 !== 1'b1) $display("FAIL rst_a_idle got %b want 1", a_idle0); else n_pass++;
    n_total++; if (a_err0 !== 1'b0) $display("FAIL rst_a_err got %b want 0", a_err0); else n_pass++;
    n_total++; if (a_req1 !== 1'b0) $display("FAIL rst_a_req_m1 got %b want 0", a_req1); else n_pass++;
    arst_n = 1'b1; asend1 = 1'b0;
    step();
    n_total++; if (a_level0 !== 3'd1) $display("FAIL first_write_level got %0d want 1", a_level0); else n_pass++;
    n_total++; if (dout0 !== 8'h00) $display("FAIL first_write_dout got %h want 00", dout0); else n_pass++;
    asend0 = 1'b0;
    step();
    n_total++; if (dout0 !== 8'hA5) $display("FAIL load_dout got %h want a5", dout0); else n_pass++;
    n_total++; if (a_level0 !== 3'd0) $display("FAIL load_level got %0d want 0", a_level0); else n_pass++;
    n_total++; if (a_req0 !== 1'b0) $display("FAIL load_req_early got %b want 0", a_req0); else n_pass++;
    step();
    n_total++; if (a_req0 !== 1'b1) $display("FAIL req_edge got %b want 1", a_req0); else n_pass++;
  endtask

  task automatic test_mode0();
    do_reset();
    adata0 = 8'h3C; asend0 = 1'b1;
    step();
    asend0 = 1'b0;
    step();
    n_total++; if (dout0 !== 8'h3C) $display("FAIL m0_load_dout got %h want 3c", dout0); else n_pass++;
    step();
    n_total++; if (a_req0 !== 1'b1) $display("FAIL m0_req got %b want 1", a_req0); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      step();
      n_total++; if (dout0 !== 8'h3C) $display("FAIL m0_hold_dout cyc %0d got %h want 3c", i, dout0); else n_pass++;
    end
    b_ack0 = 1'b1;
    // ack_s picks up the toggle on the 2nd edge; the FSM acts on it at the 3rd.
    repeat (2) step();
    n_total++; if (a_idle0 !== 1'b0) $display("FAIL m0_not_idle_yet got %b want 0", a_idle0); else n_pass++;
    step();
    n_total++; if (a_idle0 !== 1'b1) $display("FAIL m0_idle got %b want 1", a_idle0); else n_pass++;
    n_total++; if (dout0 !== 8'h3C) $display("FAIL m0_dout_after got %h want 3c", dout0); else n_pass++;
    n_total++; if (a_req0 !== 1'b1) $display("FAIL m0_req_after got %b want 1", a_req0); else n_pass++;
  endtask

  task automatic test_mode1();
    do_reset();
    adata1 = 8'h11; asend1 = 1'b1;
    step();
    adata1 = 8'h22;
    step();
    asend1 = 1'b0;
    n_total++; if (dout1 !== 8'h11) $display("FAIL m1_load1 got %h want 11", dout1); else n_pass++;
    n_total++; if (a_level1 !== 3'd1) $display("FAIL m1_level_wr_pop got %0d want 1", a_level1); else n_pass++;
    step();
    n_total++; if (a_req1 !== 1'b1) $display("FAIL m1_req1 got %b want 1", a_req1); else n_pass++;
    repeat (2) step();
    b_ack1 = 1'b1;
    repeat (2) step();
    n_total++; if (a_req1 !== 1'b1) $display("FAIL m1_req_held got %b want 1", a_req1); else n_pass++;
    step();
    n_total++; if (a_req1 !== 1'b0) $display("FAIL m1_req_fall got %b want 0", a_req1); else n_pass++;
    n_total++; if (dout1 !== 8'h11) $display("FAIL m1_dout_rel got %h want 11", dout1); else n_pass++;
    b_ack1 = 1'b0;
    repeat (2) step();
    n_total++; if (dout1 !== 8'h11) $display("FAIL m1_dout_rel2 got %h want 11", dout1); else n_pass++;
    n_total++; if (a_idle1 !== 1'b0) $display("FAIL m1_rel_idle got %b want 0", a_idle1); else n_pass++;
    step();
    n_total++; if (dout1 !== 8'h11) $display("FAIL m1_dout_idle got %h want 11", dout1); else n_pass++;
    step();
    n_total++; if (dout1 !== 8'h22) $display("FAIL m1_load2 got %h want 22", dout1); else n_pass++;
    n_total++; if (a_req1 !== 1'b0) $display("FAIL m1_req_gap got %b want 0", a_req1); else n_pass++;
    step();
    n_total++; if (a_req1 !== 1'b1) $display("FAIL m1_req2 got %b want 1", a_req1); else n_pass++;
    b_ack1 = 1'b1;
    repeat (3) step();
    n_total++; if (a_req1 !== 1'b0) $display("FAIL m1_req2_fall got %b want 0", a_req1); else n_pass++;
    b_ack1 = 1'b0;
    repeat (2) step();
    n_total++; if (a_idle1 !== 1'b0) $display("FAIL m1_rel2_idle got %b want 0", a_idle1); else n_pass++;
    step();
    n_total++; if (a_idle1 !== 1'b1) $display("FAIL m1_idle_end got %b want 1", a_idle1); else n_pass++;
    n_total++; if (dout1 !== 8'h22) $display("FAIL m1_dout_end got %h want 22", dout1); else n_pass++;
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      adata0 = 8'(i); asend0 = 1'b1;
      if (i == 6) begin
        n_total++; if (aready0 !== 1'b0) $display("FAIL fill_full_before6 got %b want 0", aready0); else n_pass++;
        n_total++; if (a_err0 !== 1'b0) $display("FAIL fill_err_before6 got %b want 0", a_err0); else n_pass++;
      end
      step();
    end
    asend0 = 1'b0;
    n_total++; if (a_level0 !== 3'd4) $display("FAIL fill_level got %0d want 4", a_level0); else n_pass++;
    n_total++; if (aready0 !== 1'b0) $display("FAIL fill_aready got %b want 0", aready0); else n_pass++;
    n_total++; if (a_err0 !== 1'b1) $display("FAIL fill_err got %b want 1", a_err0); else n_pass++;
    n_total++; if (dout0 !== 8'h01) $display("FAIL fill_inflight got %h want 01", dout0); else n_pass++;
    repeat (3) step();
    n_total++; if (a_err0 !== 1'b1) $display("FAIL fill_err_sticky got %b want 1", a_err0); else n_pass++;
    for (int k = 2; k <= 5; k++) begin
      b_ack0 = ~b_ack0;
      repeat (4) step();
      n_total++; if (dout0 !== 8'(k)) $display("FAIL fill_drain got %h want %h", dout0, 8'(k)); else n_pass++;
      step();
    end
    b_ack0 = ~b_ack0;
    repeat (3) step();
    n_total++; if (a_idle0 !== 1'b1) $display("FAIL fill_drained_idle got %b want 1", a_idle0); else n_pass++;
    n_total++; if (dout0 !== 8'h05) $display("FAIL fill_no_6th got %h want 05", dout0); else n_pass++;
    n_total++; if (aready0 !== 1'b1) $display("FAIL fill_aready_end got %b want 1", aready0); else n_pass++;
    n_total++; if (a_err0 !== 1'b1) $display("FAIL fill_err_end got %b want 1", a_err0); else n_pass++;
  endtask

  task automatic test_simul();
    do_reset();
    adata0 = 8'hC1; asend0 = 1'b1;
    step();
    n_total++; if (a_level0 !== 3'd1) $display("FAIL sim_level_pre got %0d want 1", a_level0); else n_pass++;
    adata0 = 8'hC2;
    step();
    asend0 = 1'b0;
    n_total++; if (a_level0 !== 3'd1) $display("FAIL sim_level_same got %0d want 1", a_level0); else n_pass++;
    n_total++; if (dout0 !== 8'hC1) $display("FAIL sim_first got %h want c1", dout0); else n_pass++;
    step();
    b_ack0 = 1'b1;
    repeat (4) step();
    n_total++; if (dout0 !== 8'hC2) $display("FAIL sim_second got %h want c2", dout0); else n_pass++;
    n_total++; if (a_level0 !== 3'd0) $display("FAIL sim_level_end got %0d want 0", a_level0); else n_pass++;
    step();
    b_ack0 = 1'b0;
    repeat (3) step();
    n_total++; if (a_idle0 !== 1'b1) $display("FAIL sim_idle got %b want 1", a_idle0); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      adata0 = 8'h70 + 8'(i); asend0 = 1'b1;
      step();
    end
    asend0 = 1'b0;
    n_total++; if (a_req0 !== 1'b1) $display("FAIL mid_in_req got %b want 1", a_req0); else n_pass++;
    n_total++; if (a_level0 !== 3'd2) $display("FAIL mid_queued got %0d want 2", a_level0); else n_pass++;
    #2 arst_n = 1'b0;
    #1;
    n_total++; if (a_req0 !== 1'b0) $display("FAIL mid_a_req got %b want 0", a_req0); else n_pass++;
    n_total++; if (dout0 !== 8'h00) $display("FAIL mid_dout got %h want 00", dout0); else n_pass++;
    n_total++; if (a_level0 !== 3'd0) $display("FAIL mid_level got %0d want 0", a_level0); else n_pass++;
    n_total++; if (a_err0 !== 1'b0) $display("FAIL mid_err got %b want 0", a_err0); else n_pass++;
    n_total++; if (a_idle0 !== 1'b1) $display("FAIL mid_idle got %b want 1", a_idle0); else n_pass++;
    step();
    arst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mode0();
    test_mode1();
    test_fill();
    test_simul();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
